// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory request/ack port, the
// decode-facing valid/ready port and the redirect input from execute.
// master = fetch unit side, slave = memory/decode/execute side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_out, pc_out, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, pc_out, instr_valid,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction
// over a req/ack handshake, presents it to decode under valid/ready, and
// squashes wrong-path fetches on branch/jump redirects.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    instr_fetch_unit_if.master        bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_squashed
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DRAIN,
        S_VALID
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_pending;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [ADDR_W-1:0] redirect_target;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign redirect_target = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

    // The request keeps the old address in DRAIN so the outstanding
    // transfer completes on the bus before the redirect takes effect.
    assign bus.imem_req    = !reset && (state == S_FETCH || state == S_DRAIN);
    assign bus.imem_addr   = {pc[ADDR_W-1:2], 2'b00};
    assign bus.instr_valid = !reset && (state == S_VALID);
    assign bus.instr_out   = instr_q;
    assign bus.pc_out      = pc_out_q;

    // Fetch state machine with the PC and the registered decode outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            pc_pending <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect) begin
                            pc <= redirect_target;
                        end else begin
                            instr_q  <= bus.imem_rdata;
                            pc_out_q <= pc;
                            state    <= S_VALID;
                        end
                    end else if (bus.redirect) begin
                        pc_pending <= redirect_target;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_ack) begin
                        // A redirect landing with the ack is the newest one.
                        pc    <= bus.redirect ? redirect_target : pc_pending;
                        state <= S_FETCH;
                    end else if (bus.redirect) begin
                        pc_pending <= redirect_target;
                    end
                end
                S_VALID: begin
                    if (bus.redirect) begin
                        pc    <= redirect_target;
                        state <= S_FETCH;
                    end else if (bus.instr_ready) begin
                        pc    <= pc + ADDR_W'(PC_STEP);
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetched_evt;
    logic squashed_evt;

    // Classify this cycle's events: accepted instruction or squashed work.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fetched_evt  = 1'b0;
        squashed_evt = 1'b0;
        case (state)
            S_FETCH: squashed_evt = bus.imem_ack && bus.redirect;
            S_DRAIN: squashed_evt = bus.imem_ack;
            S_VALID: begin
                squashed_evt = bus.redirect;
                fetched_evt  = !bus.redirect && bus.instr_ready;
            end
            default: ;
        endcase
    end

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (fetched_evt)  perf_fetched  <= perf_fetched + 32'd1;
            if (squashed_evt) perf_squashed <= perf_squashed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a per-cycle vector table of
// inputs and hand-computed outputs, plus a hand-written reset-in-DRAIN
// sequence. Inputs change just after the falling edge; outputs are
// compared 1 ns later, well away from the rising edge.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 32;
    localparam int NVEC   = 36;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_squashed(perf_squashed)
`endif
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pco;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(logic ack, logic [31:0] rdata, logic rdy, logic rd,
                                logic [31:0] rpc, logic req, logic [31:0] addr,
                                logic vld, logic [31:0] instr, logic [31:0] pco);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld; v.instr = instr; v.pco = pco;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for the falling edge, apply inputs, settle for 1 ns.
    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        reset           = rst;
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.instr_ready = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic req, input logic [31:0] addr,
                                 input logic vld, input logic [31:0] instr, input logic [31:0] pco);
        check({tag, ".imem_req"},    32'(bus.imem_req),    32'(req));
        check({tag, ".imem_addr"},   bus.imem_addr,        addr);
        check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(vld));
        check({tag, ".instr_out"},   bus.instr_out,        instr);
        check({tag, ".pc_out"},      bus.pc_out,           pco);
    endtask

    initial begin
        // ack/ready always 1, then delayed ack, stalled ready, redirect in
        // VALID, redirect 0x83 in FETCH with late ack, ack+redirect in FETCH,
        // repeated redirects in DRAIN, and PC wrap from 0xFFFF_FFFC to 0.
        vecs[0]  = mk(1, 32'hA000_0000, 1, 0, 0,            1, 32'h0,         0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 32'hBAD0_0001, 1, 0, 0,            0, 32'h0,         1, 32'hA000_0000, 32'h0);
        vecs[2]  = mk(1, 32'hA000_0004, 1, 0, 0,            1, 32'h4,         0, 32'hA000_0000, 32'h0);
        vecs[3]  = mk(1, 32'hBAD0_0003, 1, 0, 0,            0, 32'h4,         1, 32'hA000_0004, 32'h4);
        vecs[4]  = mk(1, 32'hA000_0008, 1, 0, 0,            1, 32'h8,         0, 32'hA000_0004, 32'h4);
        vecs[5]  = mk(1, 32'hBAD0_0005, 1, 0, 0,            0, 32'h8,         1, 32'hA000_0008, 32'h8);
        vecs[6]  = mk(0, 32'hBAD0_0006, 1, 0, 0,            1, 32'hC,         0, 32'hA000_0008, 32'h8);
        vecs[7]  = mk(0, 32'hBAD0_0007, 1, 0, 0,            1, 32'hC,         0, 32'hA000_0008, 32'h8);
        vecs[8]  = mk(0, 32'hBAD0_0008, 1, 0, 0,            1, 32'hC,         0, 32'hA000_0008, 32'h8);
        vecs[9]  = mk(1, 32'hB000_000C, 1, 0, 0,            1, 32'hC,         0, 32'hA000_0008, 32'h8);
        vecs[10] = mk(1, 32'hBAD0_000A, 0, 0, 0,            0, 32'hC,         1, 32'hB000_000C, 32'hC);
        vecs[11] = mk(1, 32'hBAD0_000B, 0, 0, 0,            0, 32'hC,         1, 32'hB000_000C, 32'hC);
        vecs[12] = mk(1, 32'hBAD0_000C, 0, 0, 0,            0, 32'hC,         1, 32'hB000_000C, 32'hC);
        vecs[13] = mk(1, 32'hBAD0_000D, 0, 0, 0,            0, 32'hC,         1, 32'hB000_000C, 32'hC);
        vecs[14] = mk(1, 32'hBAD0_000E, 0, 0, 0,            0, 32'hC,         1, 32'hB000_000C, 32'hC);
        vecs[15] = mk(1, 32'hBAD0_000F, 1, 0, 0,            0, 32'hC,         1, 32'hB000_000C, 32'hC);
        vecs[16] = mk(1, 32'hB000_0010, 1, 0, 0,            1, 32'h10,        0, 32'hB000_000C, 32'hC);
        vecs[17] = mk(1, 32'hBAD0_0011, 1, 1, 32'h40,       0, 32'h10,        1, 32'hB000_0010, 32'h10);
        vecs[18] = mk(1, 32'hB000_0040, 1, 0, 0,            1, 32'h40,        0, 32'hB000_0010, 32'h10);
        vecs[19] = mk(1, 32'hBAD0_0013, 1, 0, 0,            0, 32'h40,        1, 32'hB000_0040, 32'h40);
        vecs[20] = mk(0, 32'hBAD0_0014, 1, 1, 32'h83,       1, 32'h44,        0, 32'hB000_0040, 32'h40);
        vecs[21] = mk(0, 32'hBAD0_0015, 1, 0, 0,            1, 32'h44,        0, 32'hB000_0040, 32'h40);
        vecs[22] = mk(1, 32'hBAD0_0016, 1, 0, 0,            1, 32'h44,        0, 32'hB000_0040, 32'h40);
        vecs[23] = mk(1, 32'hC000_0080, 1, 0, 0,            1, 32'h80,        0, 32'hB000_0040, 32'h40);
        vecs[24] = mk(1, 32'hBAD0_0018, 1, 0, 0,            0, 32'h80,        1, 32'hC000_0080, 32'h80);
        vecs[25] = mk(1, 32'hBAD0_0019, 1, 1, 32'h100,      1, 32'h84,        0, 32'hC000_0080, 32'h80);
        vecs[26] = mk(0, 32'hBAD0_001A, 1, 1, 32'h200,      1, 32'h100,       0, 32'hC000_0080, 32'h80);
        vecs[27] = mk(0, 32'hBAD0_001B, 1, 1, 32'h304,      1, 32'h100,       0, 32'hC000_0080, 32'h80);
        vecs[28] = mk(1, 32'hBAD0_001C, 1, 0, 0,            1, 32'h100,       0, 32'hC000_0080, 32'h80);
        vecs[29] = mk(1, 32'hC000_0304, 1, 0, 0,            1, 32'h304,       0, 32'hC000_0080, 32'h80);
        vecs[30] = mk(1, 32'hBAD0_001E, 1, 0, 0,            0, 32'h304,       1, 32'hC000_0304, 32'h304);
        vecs[31] = mk(0, 32'hBAD0_001F, 1, 1, 32'hFFFF_FFFF, 1, 32'h308,      0, 32'hC000_0304, 32'h304);
        vecs[32] = mk(1, 32'hBAD0_0020, 1, 0, 0,            1, 32'h308,       0, 32'hC000_0304, 32'h304);
        vecs[33] = mk(1, 32'hC000_FFFC, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 32'hC000_0304, 32'h304);
        vecs[34] = mk(1, 32'hBAD0_0022, 1, 0, 0,            0, 32'hFFFF_FFFC, 1, 32'hC000_FFFC, 32'hFFFF_FFFC);
        vecs[35] = mk(0, 32'hBAD0_0023, 1, 0, 0,            1, 32'h0,         0, 32'hC000_FFFC, 32'hFFFF_FFFC);

        // Reset for three cycles with ack and ready already high.
        reset           = 1'b1;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'hBAD0_FFFF;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(1'b0, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
            check_outputs($sformatf("v%0d", i), vecs[i].req, vecs[i].addr,
                          vecs[i].vld, vecs[i].instr, vecs[i].pco);
        end

        // Reset in DRAIN with a same-cycle ack: first squash to 0x500 so
        // the reload to RESET_PC is observable, then enter DRAIN.
        drive(1'b0, 1'b1, 32'hBAD0_0100, 1'b1, 1'b1, 32'h500);
        check("h1.imem_addr", bus.imem_addr, 32'h0);
        drive(1'b0, 1'b0, 32'hBAD0_0101, 1'b1, 1'b1, 32'h40);
        check("h2.imem_addr", bus.imem_addr, 32'h500);
        check("h2.imem_req", 32'(bus.imem_req), 32'h1);
`ifdef IF_PERF_CNT_EN
        check("h2.perf_fetched",  perf_fetched,  32'd8);
        check("h2.perf_squashed", perf_squashed, 32'd6);
`endif
        drive(1'b1, 1'b1, 32'hBAD0_0102, 1'b1, 1'b0, 32'h0);
        check("h3.imem_req",    32'(bus.imem_req),    32'h0);
        check("h3.instr_valid", 32'(bus.instr_valid), 32'h0);
        drive(1'b0, 1'b0, 32'hBAD0_0103, 1'b1, 1'b0, 32'h0);
        check_outputs("h4", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("h4.perf_fetched",  perf_fetched,  32'd0);
        check("h4.perf_squashed", perf_squashed, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
